// File: rtl/fifo_wr_frontend_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_frontend_pkg
// Shared definitions for the dual-clock FIFO:
//   - default pointer / data widths
//   - skid buffer state encoding (EMPTY / ONE / TWO)
//   - gray2bin conversion, reused by both write and read sides
// ---------------------------------------------------------------------------
package fifo_wr_frontend_pkg;

    localparam int FIFO_PTR_WIDTH  = 3;
    localparam int FIFO_DATA_WIDTH = 8;

    // Widest pointer gray2bin accepts; callers zero-extend and truncate back.
    localparam int GRAY_MAX_W = 32;

    localparam logic [1:0] SKID_EMPTY = 2'd0;
    localparam logic [1:0] SKID_ONE   = 2'd1;
    localparam logic [1:0] SKID_TWO   = 2'd2;

    // Zero-extension is harmless: leading zeros do not change the XOR prefix.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_frontend_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_frontend_if
// Bundles the producer valid/ready stream and the pointer-handler / memory
// signals seen by the write front end.
//   slave  : the front end (consumes s_valid/s_data/full/pointers,
//            drives s_ready/w_en/w_data)
//   master : the surrounding environment (producer + pointer handler)
// ---------------------------------------------------------------------------
interface fifo_wr_frontend_if #(
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  full;
    logic [PTR_WIDTH:0]    b_wptr;
    logic [PTR_WIDTH:0]    g_rptr_sync;
    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_data;

    modport slave (
        input  s_valid, s_data, full, b_wptr, g_rptr_sync,
        output s_ready, w_en, w_data
    );

    modport master (
        output s_valid, s_data, full, b_wptr, g_rptr_sync,
        input  s_ready, w_en, w_data
    );
endinterface

// File: rtl/fifo_wr_frontend_skid.sv
// ---------------------------------------------------------------------------
// fifo_skid_buf
// Two-entry skid buffer between the producer and the FIFO write port.
// Ports:
//   wclk, wrst_n          clock, async active-low reset
//   s_valid_i, s_data_i   producer stream in
//   s_ready_o             buffer has a free slot (decoded from count only)
//   full_i                FIFO full from the pointer handler
//   w_en_o, w_data_o      write request and head-of-buffer data
// ---------------------------------------------------------------------------
module fifo_skid_buf
    import fifo_wr_frontend_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    input  logic                  full_i,
    output logic                  w_en_o,
    output logic [DATA_WIDTH-1:0] w_data_o
);

    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    logic                  acc;
    logic                  drain;

    // Flop-only decode keeps full/s_valid off the s_ready timing path.
    assign s_ready_o = (count_q != SKID_TWO);
    assign drain     = (count_q != SKID_EMPTY) & ~full_i;
    assign acc       = s_valid_i & s_ready_o;
    assign w_en_o    = drain;
    assign w_data_o  = ent0_q;

    always_comb begin
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        case (count_q)
            SKID_EMPTY: begin
                if (acc) begin
                    ent0_d  = s_data_i;
                    count_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (acc && drain) begin
                    // Head leaves this cycle, so the new word takes its place.
                    ent0_d = s_data_i;
                end else if (acc) begin
                    ent1_d  = s_data_i;
                    count_d = SKID_TWO;
                end else if (drain) begin
                    count_d = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                // s_ready is low here, so only a drain can happen.
                if (drain) begin
                    ent0_d  = ent1_q;
                    count_d = SKID_ONE;
                end
            end
            default: begin
                count_d = SKID_EMPTY;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            count_q <= SKID_EMPTY;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

endmodule

// File: rtl/fifo_wr_frontend.sv
// ---------------------------------------------------------------------------
// fifo_wr_frontend
// Write-domain front end of the dual-clock FIFO: skid-buffers the producer
// stream, gates writes on full, and tracks write-side fill level,
// almost_full and a clearable peak level.
// Ports:
//   wclk, wrst_n   write clock, async active-low reset
//   bus (slave)    s_valid/s_data/s_ready, full, b_wptr, g_rptr_sync,
//                  w_en/w_data
//   peak_clr       synchronous clear (and recapture) of the peak monitor
//   wr_level       registered occupancy 0..2^PTR_WIDTH
//   almost_full    registered wr_level >= AF_THRESH
//   peak_level     highest wr_level since reset or last clear
// ---------------------------------------------------------------------------
module fifo_wr_frontend
    import fifo_wr_frontend_pkg::*;
#(
    parameter int PTR_WIDTH  = FIFO_PTR_WIDTH,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int AF_THRESH  = 6
) (
    input  logic                   wclk,
    input  logic                   wrst_n,
    fifo_wr_frontend_if.slave      bus,
    input  logic                   peak_clr,
    output logic [PTR_WIDTH:0]     wr_level,
    output logic                   almost_full,
    output logic [PTR_WIDTH:0]     peak_level
);

    localparam int                 LW     = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] AF_LVL = LW'(AF_THRESH);

    logic [PTR_WIDTH:0] r_bin;
    logic [PTR_WIDTH:0] level_next;
    logic [PTR_WIDTH:0] wr_level_q, wr_level_d;
    logic               af_q, af_d;
    logic [PTR_WIDTH:0] peak_q, peak_d;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .s_valid_i (bus.s_valid),
        .s_data_i  (bus.s_data),
        .s_ready_o (bus.s_ready),
        .full_i    (bus.full),
        .w_en_o    (bus.w_en),
        .w_data_o  (bus.w_data)
    );

    assign r_bin = LW'(gray2bin(GRAY_MAX_W'(bus.g_rptr_sync)));

    // Modular subtraction in PTR_WIDTH+1 bits absorbs pointer wrap.
    assign level_next = bus.b_wptr - r_bin;

    always_comb begin
        wr_level_d = level_next;
        af_d       = (level_next >= AF_LVL);
        peak_d     = peak_q;
        if (peak_clr) begin
            // Clearing recaptures the current level rather than zero.
            peak_d = level_next;
        end else if (level_next > peak_q) begin
            peak_d = level_next;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wr_level_q <= '0;
            af_q       <= 1'b0;
            peak_q     <= '0;
        end else begin
            wr_level_q <= wr_level_d;
            af_q       <= af_d;
            peak_q     <= peak_d;
        end
    end

    assign wr_level    = wr_level_q;
    assign almost_full = af_q;
    assign peak_level  = peak_q;

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_frontend
// Self-checking bench: a queue-based model of the buffer plus an arithmetic
// level model is compared with the DUT every cycle; directed literal checks
// pin the model on the documented scenarios.
// ---------------------------------------------------------------------------
module tb_fifo_wr_frontend;

    logic       wclk;
    logic       wrst_n;
    logic       peak_clr;
    logic [3:0] wr_level;
    logic       almost_full;
    logic [3:0] peak_level;

    int checks = 0;
    int errors = 0;

    // Environment model of the pointer handler's full flag.
    int  wcnt;
    int  rcnt;
    bit  auto_full;

    fifo_wr_frontend_if #(.PTR_WIDTH(3), .DATA_WIDTH(8)) bus ();

    fifo_wr_frontend #(
        .PTR_WIDTH  (3),
        .DATA_WIDTH (8),
        .AF_THRESH  (6)
    ) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .bus         (bus.slave),
        .peak_clr    (peak_clr),
        .wr_level    (wr_level),
        .almost_full (almost_full),
        .peak_level  (peak_level)
    );

    assign bus.full = auto_full && ((wcnt - rcnt) >= 8);

    always #5 wclk = ~wclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Gray decode by search: the value whose Gray code matches.
    function automatic int g2b(input int g);
        for (int v = 0; v < 16; v++) begin
            if ((v ^ (v >> 1)) == g) return v;
        end
        return 0;
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    logic [7:0] dut_log[$];
    int exp_level, exp_af, exp_peak;

    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wcnt <= 0;
        end else if (bus.w_en) begin
            wcnt <= wcnt + 1;
        end
    end

    always @(posedge wclk or negedge wrst_n) begin
        int  lvl;
        bit  m_acc, m_wen;
        if (!wrst_n) begin
            mq.delete();
            exp_level <= 0;
            exp_af    <= 0;
            exp_peak  <= 0;
        end else begin
            m_acc = bus.s_valid && (mq.size() < 2);
            m_wen = (mq.size() > 0) && !bus.full;
            if (m_wen) void'(mq.pop_front());
            if (m_acc) mq.push_back(bus.s_data);
            lvl = (int'(bus.b_wptr) - g2b(int'(bus.g_rptr_sync))) & 15;
            exp_level <= lvl;
            exp_af    <= (lvl >= 6) ? 1 : 0;
            if (peak_clr) exp_peak <= lvl;
            else if (lvl > exp_peak) exp_peak <= lvl;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge wclk) begin
        bit exp_wen;
        if (wrst_n) begin
            exp_wen = (mq.size() > 0) && !bus.full;
            chk("s_ready", 32'(bus.s_ready), 32'(mq.size() < 2));
            chk("w_en", 32'(bus.w_en), 32'(exp_wen));
            if (exp_wen && bus.w_en) chk("w_data", 32'(bus.w_data), 32'(mq[0]));
            chk("wr_level", 32'(wr_level), 32'(exp_level));
            chk("almost_full", 32'(almost_full), 32'(exp_af));
            chk("peak_level", 32'(peak_level), 32'(exp_peak));
            if (bus.w_en) dut_log.push_back(bus.w_data);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge wclk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d);
        int   t;
        logic rdy;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge wclk);
            rdy = bus.s_ready;
            @(posedge wclk);
            #1;
            if (rdy) break;
            t++;
            if (t > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout word=%0d waited=%0d cycles", d, t);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] af_lv [5];
        logic       af_ex [5];
        af_lv = '{4'd5, 4'd6, 4'd8, 4'd6, 4'd5};
        af_ex = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        wclk = 0;
        wrst_n = 0;
        peak_clr = 0;
        auto_full = 0;
        rcnt = 0;
        bus.s_valid = 0;
        bus.s_data = 8'h00;
        bus.b_wptr = 4'd0;
        bus.g_rptr_sync = 4'd0;

        #12;
        chk("rst_s_ready", 32'(bus.s_ready), 1);
        chk("rst_w_en", 32'(bus.w_en), 0);
        chk("rst_w_data", 32'(bus.w_data), 0);
        chk("rst_wr_level", 32'(wr_level), 0);
        chk("rst_almost_full", 32'(almost_full), 0);
        chk("rst_peak", 32'(peak_level), 0);
        wrst_n = 1;
        step(1);

        // Peak monitor: 3,7,4 -> 7; clear at 4 -> 4; then 5 -> 5
        bus.b_wptr = 4'd3; step(1);
        bus.b_wptr = 4'd7; step(1);
        bus.b_wptr = 4'd4; step(1);
        chk("peak_3_7_4", 32'(peak_level), 7);
        chk("level_4", 32'(wr_level), 4);
        peak_clr = 1; step(1);
        chk("peak_clr_4", 32'(peak_level), 4);
        peak_clr = 0; bus.b_wptr = 4'd5; step(1);
        chk("peak_5", 32'(peak_level), 5);

        // Level arithmetic including wrap
        bus.b_wptr = 4'b1010; bus.g_rptr_sync = 4'b0111; step(1);
        chk("level_10_5", 32'(wr_level), 5);
        chk("af_level5", 32'(almost_full), 0);
        bus.b_wptr = 4'b0001; bus.g_rptr_sync = 4'b1001; step(1);
        chk("level_wrap", 32'(wr_level), 3);

        // Almost-full threshold edge
        bus.g_rptr_sync = 4'd0;
        for (int i = 0; i < 5; i++) begin
            bus.b_wptr = af_lv[i];
            step(1);
            chk($sformatf("af_edge_%0d", i), 32'(almost_full), 32'(af_ex[i]));
        end

        // Fill to full: 10 words, full after 8 writes
        bus.b_wptr = 4'd0;
        rcnt = wcnt;
        auto_full = 1;
        dut_log.delete();
        step(1);
        for (int i = 0; i < 10; i++) send(8'(i));
        bus.s_valid = 0;
        step(3);
        @(negedge wclk);
        chk("full_w_en_low", 32'(bus.w_en), 0);
        chk("full_s_ready_low", 32'(bus.s_ready), 0);
        step(1);
        chk("full_write_count", 32'(dut_log.size()), 8);
        for (int i = 0; i < 8 && i < dut_log.size(); i++)
            chk($sformatf("full_word_%0d", i), 32'(dut_log[i]), 32'(i));
        rcnt = rcnt + 2;
        step(4);
        chk("drain_count", 32'(dut_log.size()), 10);
        if (dut_log.size() >= 10) begin
            chk("drain_word_8", 32'(dut_log[8]), 8);
            chk("drain_word_9", 32'(dut_log[9]), 9);
        end
        auto_full = 0;
        step(1);

        // Throughput: continuous valid, not full
        bus.s_data = 8'h40;
        bus.s_valid = 1;
        for (int k = 0; k < 10; k++) begin
            @(posedge wclk);
            #1;
            bus.s_data = bus.s_data + 8'd1;
            @(negedge wclk);
            chk($sformatf("tput_w_en_%0d", k), 32'(bus.w_en), 1);
            chk($sformatf("tput_s_ready_%0d", k), 32'(bus.s_ready), 1);
        end

        // Reset mid-stream
        @(posedge wclk);
        #1;
        bus.b_wptr = 4'd7;
        step(2);
        chk("pre_rst_level", 32'(wr_level), 7);
        wrst_n = 0;
        #1;
        chk("mid_rst_s_ready", 32'(bus.s_ready), 1);
        chk("mid_rst_w_en", 32'(bus.w_en), 0);
        chk("mid_rst_w_data", 32'(bus.w_data), 0);
        chk("mid_rst_wr_level", 32'(wr_level), 0);
        chk("mid_rst_almost_full", 32'(almost_full), 0);
        chk("mid_rst_peak", 32'(peak_level), 0);
        bus.s_valid = 0;
        step(2);
        wrst_n = 1;
        @(negedge wclk);
        chk("post_rst_s_ready", 32'(bus.s_ready), 1);
        chk("post_rst_w_en", 32'(bus.w_en), 0);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
